// File: rtl/ifm_pkg.sv
// Shared constants, lane derivation and FSM state type for the IFM loader.
package ifm_pkg;

  localparam int IFM_IN_W   = 32;
  localparam int IFM_DATA_W = 128;
  localparam int IFM_ADDR_W = 10;  // must match the IFM buffer address width

  function automatic int ifm_lanes(input int data_w, input int in_w);
    return data_w / in_w;
  endfunction

  localparam int IFM_LANES = ifm_lanes(IFM_DATA_W, IFM_IN_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ifm_state_e;

endpackage

// File: rtl/ifm_word_packer.sv
// Packs IN_W-bit beats little-endian into DATA_W-bit words and emits a
// registered write strobe with the packed word when a word completes or is flushed.
module ifm_word_packer
  import ifm_pkg::*;
#(
  parameter int IN_W   = IFM_IN_W,
  parameter int DATA_W = IFM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_beat,
  input  logic              i_flush,
  input  logic [IN_W-1:0]   i_data,
  output logic              o_lane_last,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data
);

  localparam int LANES  = ifm_lanes(DATA_W, IN_W);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANE_W-1:0] r_lane_cnt;
  logic [DATA_W-1:0] r_lanes;
  logic [DATA_W-1:0] w_merged;
  logic              w_emit;

  always_comb begin
    w_merged = r_lanes;
    w_merged[r_lane_cnt*IN_W +: IN_W] = i_data;
  end

  assign o_lane_last = (r_lane_cnt == LAST_LANE);
  assign w_emit      = i_beat & (o_lane_last | i_flush);

  // The lane register is zeroed after every emitted word, so a flushed
  // partial word already carries zeros in its unfilled upper lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane_cnt <= '0;
      r_lanes    <= '0;
      o_wr_en    <= 1'b0;
      o_wr_data  <= '0;
    end else begin
      o_wr_en <= w_emit;
      if (i_clear) begin
        r_lane_cnt <= '0;
        r_lanes    <= '0;
      end else if (w_emit) begin
        o_wr_data  <= w_merged;
        r_lanes    <= '0;
        r_lane_cnt <= '0;
      end else if (i_beat) begin
        r_lanes    <= w_merged;
        r_lane_cnt <= r_lane_cnt + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/ifm_loader.sv
// Loads one tile of packed words into the IFM buffer per start request:
// FSM, word/address counters and sticky framing error around the word packer.
module ifm_loader
  import ifm_pkg::*;
#(
  parameter int IN_W   = IFM_IN_W,
  parameter int DATA_W = IFM_DATA_W,
  parameter int ADDR_W = IFM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ifm_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, r_wr_addr;
  logic [ADDR_W:0]   r_num_words, r_word_cnt;
  logic              r_s_ready, r_busy, r_done, r_err;
  logic              w_start_ok, w_beat, w_lane_last, w_last_word;
  logic              w_tile_end, w_flush, w_word_done;
  logic              w_s_ready_nxt, w_busy_nxt, w_done_nxt, w_err_set;

  assign w_start_ok  = start & (r_state == ST_IDLE);
  assign w_beat      = s_valid & r_s_ready;
  assign w_last_word = ((r_word_cnt + (ADDR_W+1)'(1)) == r_num_words);
  assign w_tile_end  = w_beat & w_lane_last & w_last_word;
  assign w_flush     = w_beat & s_last & ~w_tile_end;
  assign w_word_done = w_beat & (w_lane_last | s_last);

  ifm_word_packer #(.IN_W(IN_W), .DATA_W(DATA_W)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_ok),
    .i_beat      (w_beat),
    .i_flush     (w_flush),
    .i_data      (s_data),
    .o_lane_last (w_lane_last),
    .o_wr_en     (wr_en),
    .o_wr_data   (wr_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = (num_words == '0) ? ST_DONE : ST_LOAD;
        else            w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_tile_end | w_flush) w_state_nxt = ST_DONE;
        else                      w_state_nxt = ST_LOAD;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode, evaluated one cycle ahead so every output is a flop
  always_comb begin
    w_s_ready_nxt = (w_state_nxt == ST_LOAD);
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_done_nxt    = (r_state == ST_DONE);
    w_err_set     = (w_tile_end & ~s_last) | w_flush;
  end

  // Tile parameters, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_wr_addr   <= '0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (w_start_ok) begin
        r_base      <= base_addr;
        r_num_words <= num_words;
        r_word_cnt  <= '0;
        r_err       <= 1'b0;
      end else begin
        if (w_word_done) begin
          r_wr_addr  <= r_base + r_word_cnt[ADDR_W-1:0];
          r_word_cnt <= r_word_cnt + (ADDR_W+1)'(1);
        end
        if (w_err_set) r_err <= 1'b1;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign wr_addr = r_wr_addr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_ifm_loader.sv
// Self-checking bench for ifm_loader: scoreboard of expected buffer writes
// (address, data, cycle) plus per-scenario status checks.
module tb_ifm_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [9:0]   base_addr;
  logic [10:0]  num_words;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         busy;
  logic         done;
  logic         err;

  typedef struct {
    logic [9:0]   a;
    logic [127:0] d;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_wr  = 1'b0;

  ifm_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample #1 after the edge and retire scoreboard entries.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en) begin
      n_checks++;
      if (prev_wr) begin
        n_fail++;
        $display("FAIL wr_back_to_back: wr_en high in cycles %0d and %0d, required isolated", cyc - 1, cyc);
      end
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h data=%h at cycle %0d, required no write", wr_addr, wr_data, cyc);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d || cyc != e.due) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   wr_addr, wr_data, cyc, e.a, e.d, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_write: no wr_en at cycle %0d, required addr=%h data=%h", cyc, e.a, e.d);
    end
    prev_wr = wr_en;
  endtask

  task automatic start_tile(input logic [9:0] base, input logic [10:0] num);
    start = 1'b1; base_addr = base; num_words = num;
    tick();
    start = 1'b0; base_addr = 10'h155; num_words = 11'd3;
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b err=%b, required busy=1 err=0", busy, err);
    end
  endtask

  task automatic run_tile(input logic [9:0] base, input logic [10:0] num, input int nbeats,
                          input int last_at, input int doff, input bit gaps, input bit poke,
                          input bit exp_err, input string nm);
    int lane = 0;
    int word = 0;
    bit ended = 1'b0;
    logic [127:0] pack = '0;
    exp_t e;
    start_tile(base, num);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: s_ready=%b, required 1", nm, s_ready);
    end
    for (int i = 1; i <= nbeats && !ended; i++) begin
      if (gaps && i > 1) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = 32'(doff + i);
      s_last  = (i == last_at);
      if (poke && i == 2) begin
        start = 1'b1; base_addr = 10'h200; num_words = 11'd5;
      end
      pack[lane*32 +: 32] = 32'(doff + i);
      if (lane == 3 || i == last_at) begin
        e.a = base + 10'(word);
        e.d = pack;
        e.due = cyc + 1;
        sb.push_back(e);
        pack = '0;
        lane = 0;
        word++;
        if (i == last_at || word == int'(num)) ended = 1'b1;
      end else begin
        lane++;
      end
      tick();
      start = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_doneState: busy=%b done=%b err=%b, required busy=1 done=0 err=%b", nm, busy, done, err, exp_err);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || s_ready !== 1'b0 || err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_done: busy=%b done=%b s_ready=%b err=%b, required 0 1 0 %b", nm, busy, done, s_ready, err, exp_err);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d writes outstanding, required 0", nm, sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({s_ready, wr_en, busy, done, err} !== 5'b00000 || wr_addr !== 10'h000 || wr_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset: ready/wr_en/busy/done/err=%b addr=%h data=%h, required all 0",
               {s_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    end
    tick();
  endtask

  task automatic test_nominal();
    run_tile(10'h010, 11'd2, 8, 8, 0, 1'b0, 1'b0, 1'b0, "nominal");
  endtask

  task automatic test_bubbles();
    run_tile(10'h010, 11'd2, 8, 8, 0, 1'b1, 1'b0, 1'b0, "bubbles");
  endtask

  task automatic test_wrap();
    run_tile(10'h3FF, 11'd2, 8, 8, 32'h40, 1'b0, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_early_last();
    run_tile(10'h080, 11'd2, 8, 6, 0, 1'b0, 1'b0, 1'b1, "early_last");
    run_tile(10'h090, 11'd1, 4, 4, 32'h20, 1'b0, 1'b0, 1'b0, "err_clear");
  endtask

  task automatic test_missing_last();
    run_tile(10'h020, 11'd1, 4, 0, 32'h30, 1'b0, 1'b0, 1'b1, "missing_last");
  endtask

  task automatic test_zero_words();
    start_tile(10'h040, 11'd0);
    n_checks++;
    if (wr_en !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_words_s1: wr_en=%b done=%b, required 0 0", wr_en, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_words_s2: done=%b busy=%b wr_en=%b, required 1 0 0", done, busy, wr_en);
    end
    tick();
  endtask

  task automatic test_start_in_load();
    run_tile(10'h060, 11'd2, 8, 8, 32'h50, 1'b0, 1'b1, 1'b0, "start_in_load");
  endtask

  task automatic test_reset_mid_tile();
    start_tile(10'h100, 11'd2);
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1; s_data = 32'(32'h70 + i); s_last = 1'b0;
      tick();
    end
    s_data = 32'h74; rst = 1'b1;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    n_checks++;
    if ({s_ready, wr_en, busy, done, err} !== 5'b00000 || wr_addr !== 10'h000 || wr_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid_tile: ready/wr_en/busy/done/err=%b addr=%h data=%h, required all 0",
               {s_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    end
    tick();
    run_tile(10'h100, 11'd1, 4, 4, 32'h10, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bubbles();
    test_wrap();
    test_early_last();
    test_missing_last();
    test_zero_words();
    test_start_in_load();
    test_reset_mid_tile();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
